// File: rtl/alu_req_arbiter_pkg.sv
// ============================================================================
// Module  : alu_req_arbiter_pkg
// Brief   : Shared ALU constants, status bit indices and controller states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_req_arbiter_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int OPW_DEFAULT   = 4;

  // statusOut bit positions
  localparam int ST_NEG      = 3;
  localparam int ST_ZERO     = 2;
  localparam int ST_CARRY    = 1;
  localparam int ST_OVERFLOW = 0;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_req_arbiter_rr_arbiter2.sv
// ============================================================================
// Module  : rr_arbiter2
// Brief   : Two-way combinational round-robin pick; ties go to !last_grant.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
  import alu_req_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |valid;
    if (&valid) begin
      grant = ~last_grant;
    end else begin
      grant = valid[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_req_arbiter.sv
// ============================================================================
// Module  : alu_req_arbiter
// Brief   : Shares one combinational ALU between two requesters, one op in flight.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int OPW   = OPW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_operand1,
  input  logic [WIDTH-1:0] req0_operand2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_operand1,
  input  logic [WIDTH-1:0] req1_operand2,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       statusOut,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_operand1,
  output logic [WIDTH-1:0] alu_operand2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_status,
  output logic             busy
);

  state_t           r_state;
  state_t           w_next;
  logic             r_owner;
  logic             r_last_grant;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_operand1;
  logic [WIDTH-1:0] r_operand2;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_status;

  logic w_grant;
  logic w_grant_valid;
  logic w_accept;
  logic w_capture;
  logic w_done;

  rr_arbiter2 u_rr (
    .valid       ({req1_valid, req0_valid}),
    .last_grant  (r_last_grant),
    .grant       (w_grant),
    .grant_valid (w_grant_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Gated by rst so no requester sees an accept that reset will discard.
        if (!rst && w_grant_valid) begin
          w_accept   = 1'b1;
          req0_ready = ~w_grant;
          req1_ready = w_grant;
          w_next     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_capture = 1'b1;
        w_next    = ST_RESP;
      end
      ST_RESP: begin
        resp0_valid = ~r_owner;
        resp1_valid = r_owner;
        if (r_owner ? resp1_ready : resp0_ready) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_op         <= '0;
      r_operand1   <= '0;
      r_operand2   <= '0;
      r_result     <= '0;
      r_status     <= '0;
    end else begin
      if (w_accept) begin
        r_owner    <= w_grant;
        r_op       <= w_grant ? req1_op       : req0_op;
        r_operand1 <= w_grant ? req1_operand1 : req0_operand1;
        r_operand2 <= w_grant ? req1_operand2 : req0_operand2;
      end
      if (w_capture) begin
        r_result <= alu_result;
        r_status <= alu_status;
      end
      if (w_done) begin
        r_last_grant <= r_owner;
      end
    end
  end

  // The ALU only ever sees latched operands, never the live request buses.
  assign alu_op       = r_op;
  assign alu_operand1 = r_operand1;
  assign alu_operand2 = r_operand2;
  assign result       = r_result;
  assign statusOut    = r_status;
  assign busy         = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
// ============================================================================
// Module  : tb_alu_req_arbiter
// Brief   : Scoreboard bench for alu_req_arbiter with a behavioural ALU model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_req_arbiter;
  import alu_req_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [15:0] req0_operand1, req0_operand2, req1_operand1, req1_operand2;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [15:0] result;
  logic [3:0]  statusOut;
  logic [3:0]  alu_op;
  logic [15:0] alu_operand1, alu_operand2, alu_result;
  logic [3:0]  alu_status;
  logic        busy;

  typedef struct {
    int          who;
    logic [15:0] res;
    logic [3:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   grant_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] ops [5] = '{OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB};

  alu_req_arbiter #(.WIDTH(16), .OPW(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_op       (req0_op),
    .req0_operand1 (req0_operand1),
    .req0_operand2 (req0_operand2),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_op       (req1_op),
    .req1_operand1 (req1_operand1),
    .req1_operand2 (req1_operand2),
    .resp0_valid   (resp0_valid),
    .resp0_ready   (resp0_ready),
    .resp1_valid   (resp1_valid),
    .resp1_ready   (resp1_ready),
    .result        (result),
    .statusOut     (statusOut),
    .alu_op        (alu_op),
    .alu_operand1  (alu_operand1),
    .alu_operand2  (alu_operand2),
    .alu_result    (alu_result),
    .alu_status    (alu_status),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {status, result}
  function automatic logic [19:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, v;
    logic [3:0]  st;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0]; c = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[15:0]; c = s[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      default: r = 16'h0000;
    endcase
    st = '0;
    st[ST_NEG]      = r[15];
    st[ST_ZERO]     = (r == 16'h0000);
    st[ST_CARRY]    = c;
    st[ST_OVERFLOW] = v;
    return {st, r};
  endfunction

  always_comb {alu_status, alu_result} = alu_model(alu_op, alu_operand1, alu_operand2);

  function automatic exp_t mk(input int who, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [19:0] m;
    exp_t e;
    m = alu_model(op, a, b);
    e.who = who;
    e.res = m[15:0];
    e.st  = m[19:16];
    return e;
  endfunction

  // Expected responses enter the scoreboard at the accepting clock edge
  always @(posedge clk) begin
    if (!rst && req0_valid && req0_ready) begin
      exp_q.push_back(mk(0, req0_op, req0_operand1, req0_operand2));
      grant_q.push_back(0);
    end
    if (!rst && req1_valid && req1_ready) begin
      exp_q.push_back(mk(1, req1_op, req1_operand1, req1_operand2));
      grant_q.push_back(1);
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (n == 0) begin
      req0_valid = v; req0_op = op; req0_operand1 = a; req0_operand2 = b;
    end else begin
      req1_valid = v; req1_op = op; req1_operand1 = a; req1_operand2 = b;
    end
  endtask

  task automatic test_reset();
    drive_edge();
    drive_edge();
    sample();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (result !== 16'h0000 || statusOut !== 4'h0) begin
      n_fail++; $display("FAIL reset_result: got %h/%h want 0000/0", result, statusOut);
    end
    n_checks++;
    if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_handshake: got %b%b%b%b want 0000", resp0_valid, resp1_valid, req0_ready, req1_ready);
    end
    n_checks++;
    if (alu_op !== 4'h0 || alu_operand1 !== 16'h0 || alu_operand2 !== 16'h0) begin
      n_fail++; $display("FAIL reset_alu_regs: got %h %h %h want 0", alu_op, alu_operand1, alu_operand2);
    end
  endtask

  task automatic test_single();
    exp_t e;
    drive_edge();
    rst = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    set_req(0, 1'b1, OP_AND, 16'hF0F0, 16'h0FF0);
    sample();
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_accept: got r0=%b r1=%b busy=%b want 1 0 0", req0_ready, req1_ready, busy);
    end
    drive_edge();
    req0_valid = 1'b0;
    sample();
    n_checks++;
    if (busy !== 1'b1 || resp0_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_exec: got busy=%b resp0=%b want 1 0", busy, resp0_valid);
    end
    n_checks++;
    if (alu_op !== OP_AND || alu_operand1 !== 16'hF0F0 || alu_operand2 !== 16'h0FF0) begin
      n_fail++; $display("FAIL single_alu_drive: got %h %h %h want 0 f0f0 0ff0", alu_op, alu_operand1, alu_operand2);
    end
    drive_edge();
    sample();
    n_checks++;
    if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_resp_valid: got r0=%b r1=%b busy=%b want 1 0 1", resp0_valid, resp1_valid, busy);
    end
    n_checks++;
    if (result !== 16'h00F0 || statusOut !== 4'b0000) begin
      n_fail++; $display("FAIL single_result: got %h/%b want 00f0/0000", result, statusOut);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL single_sb: got empty scoreboard want one entry");
    end else begin
      e = exp_q.pop_front();
      if (e.who != 0 || result !== e.res || statusOut !== e.st) begin
        n_fail++; $display("FAIL single_sb: got %h/%b want who=%0d %h/%b", result, statusOut, e.who, e.res, e.st);
      end
    end
    drive_edge();
    sample();
    n_checks++;
    if (busy !== 1'b0 || resp0_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_return_idle: got busy=%b resp0=%b want 0 0", busy, resp0_valid);
    end
  endtask

  task automatic test_both();
    exp_t e;
    int   got;
    int   cyc;
    int   who;
    bit   drop0, drop1;
    drive_edge();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drive_edge();
    rst = 1'b0;
    exp_q.delete(); grant_q.delete();
    set_req(0, 1'b1, OP_AND, 16'h8001, 16'hFFFF);
    set_req(1, 1'b1, OP_AND, 16'h00FF, 16'hFF00);
    sample();
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL both_first_grant: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    drop0 = 1'b1; drop1 = 1'b0; got = 0; cyc = 0;
    while (cyc < 20 && got < 2) begin
      drive_edge();
      if (drop0) req0_valid = 1'b0;
      if (drop1) req1_valid = 1'b0;
      drop0 = 1'b0; drop1 = 1'b0;
      sample();
      if (req0_ready) drop0 = 1'b1;
      if (req1_ready) drop1 = 1'b1;
      if (busy) begin
        n_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          n_fail++; $display("FAIL both_ready_while_busy: got %b%b want 00", req0_ready, req1_ready);
        end
      end
      if (resp0_valid || resp1_valid) begin
        who = resp1_valid ? 1 : 0;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL both_sb: got response from %0d want none", who);
        end else begin
          e = exp_q.pop_front();
          if (e.who != who || result !== e.res || statusOut !== e.st || (resp0_valid && resp1_valid)) begin
            n_fail++; $display("FAIL both_sb: got who=%0d %h/%b want who=%0d %h/%b", who, result, statusOut, e.who, e.res, e.st);
          end
        end
        n_checks++;
        if (got == 0) begin
          if (who != 0 || result !== 16'h8001 || statusOut[ST_NEG] !== 1'b1) begin
            n_fail++; $display("FAIL both_req0_neg: got who=%0d %h/%b want 0 8001 neg", who, result, statusOut);
          end
        end else begin
          if (who != 1 || result !== 16'h0000 || statusOut[ST_ZERO] !== 1'b1) begin
            n_fail++; $display("FAIL both_req1_zero: got who=%0d %h/%b want 1 0000 zero", who, result, statusOut);
          end
        end
        got++;
      end
      cyc++;
    end
    n_checks++;
    if (got < 2) begin n_fail++; $display("FAIL both_timeout: got %0d responses want 2", got); end
  endtask

  task automatic test_fairness();
    exp_t e;
    int   got;
    int   cyc;
    int   who;
    bit   new0, new1;
    drive_edge();
    grant_q.delete();
    set_req(0, 1'b1, ops[$urandom_range(4)], 16'($urandom), 16'($urandom));
    set_req(1, 1'b1, ops[$urandom_range(4)], 16'($urandom), 16'($urandom));
    new0 = 1'b0; new1 = 1'b0; got = 0; cyc = 0;
    while (cyc < 60 && got < 6) begin
      if (cyc > 0) drive_edge();
      if (new0) set_req(0, 1'b1, ops[$urandom_range(4)], 16'($urandom), 16'($urandom));
      if (new1) set_req(1, 1'b1, ops[$urandom_range(4)], 16'($urandom), 16'($urandom));
      new0 = 1'b0; new1 = 1'b0;
      sample();
      if (req0_ready) new0 = 1'b1;
      if (req1_ready) new1 = 1'b1;
      if (resp0_valid || resp1_valid) begin
        who = resp1_valid ? 1 : 0;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL fair_sb: got response from %0d want none", who);
        end else begin
          e = exp_q.pop_front();
          if (e.who != who || result !== e.res || statusOut !== e.st) begin
            n_fail++; $display("FAIL fair_sb: got who=%0d %h/%b want who=%0d %h/%b", who, result, statusOut, e.who, e.res, e.st);
          end
        end
        got++;
      end
      cyc++;
    end
    drive_edge();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (got < 6 || grant_q.size() != 6) begin
      n_fail++; $display("FAIL fair_count: got %0d responses %0d grants want 6 6", got, grant_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (grant_q[i] != (i % 2)) begin
          n_fail++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, grant_q[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    exp_t head;
    int   cyc;
    bit   seen;
    drive_edge();
    resp0_ready = 1'b0;
    resp1_ready = 1'b1;
    set_req(0, 1'b1, OP_ADD, 16'h7FFF, 16'h0001);
    set_req(1, 1'b1, OP_SUB, 16'($urandom), 16'($urandom));
    sample();
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_grant: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    drive_edge();
    req0_valid = 1'b0;
    sample();
    seen = resp0_valid; cyc = 0;
    while (!seen && cyc < 5) begin
      drive_edge();
      sample();
      seen = resp0_valid;
      cyc++;
    end
    n_checks++;
    if (!seen || exp_q.size() == 0) begin
      n_fail++; $display("FAIL stall_resp_timeout: got resp0_valid=%b want 1", resp0_valid);
    end else begin
      head = exp_q[0];
      n_checks++;
      if (result !== 16'h8000 || statusOut !== 4'b1001) begin
        n_fail++; $display("FAIL stall_add_overflow: got %h/%b want 8000/1001", result, statusOut);
      end
      for (int i = 0; i < 10; i++) begin
        drive_edge();
        req1_operand1 = 16'($urandom);
        req1_operand2 = 16'($urandom);
        sample();
        n_checks++;
        if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0
            || result !== head.res || statusOut !== head.st) begin
          n_fail++; $display("FAIL stall_hold[%0d]: got v=%b%b rdy=%b%b %h/%b want v=10 rdy=00 %h/%b",
                             i, resp0_valid, resp1_valid, req0_ready, req1_ready, result, statusOut, head.res, head.st);
        end
      end
      drive_edge();
      resp0_ready = 1'b1;
      sample();
      e = exp_q.pop_front();
      n_checks++;
      if (resp0_valid !== 1'b1 || e.who != 0 || result !== e.res || statusOut !== e.st) begin
        n_fail++; $display("FAIL stall_release: got v=%b %h/%b want v=1 %h/%b", resp0_valid, result, statusOut, e.res, e.st);
      end
      drive_edge();
      sample();
      n_checks++;
      if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL stall_next_grant: got r1=%b want 1", req1_ready); end
      drive_edge();
      req1_valid = 1'b0;
      sample();
      seen = resp1_valid; cyc = 0;
      while (!seen && cyc < 5) begin
        drive_edge();
        sample();
        seen = resp1_valid;
        cyc++;
      end
      n_checks++;
      if (!seen || exp_q.size() == 0) begin
        n_fail++; $display("FAIL stall_req1_resp: got resp1_valid=%b want 1", resp1_valid);
      end else begin
        e = exp_q.pop_front();
        if (e.who != 1 || result !== e.res || statusOut !== e.st) begin
          n_fail++; $display("FAIL stall_req1_resp: got %h/%b want who=%0d %h/%b", result, statusOut, e.who, e.res, e.st);
        end
      end
    end
    drive_edge();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_rst_exec();
    exp_t e;
    int   cyc;
    bit   seen;
    drive_edge();
    set_req(1, 1'b1, OP_OR, 16'h1234, 16'h4321);
    sample();
    n_checks++;
    if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL rst_setup_grant: got r1=%b want 1", req1_ready); end
    drive_edge();
    req1_valid = 1'b0;
    rst = 1'b1;
    sample();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_in_exec: got busy=%b want 1", busy); end
    drive_edge();
    rst = 1'b0;
    exp_q.delete();
    sample();
    n_checks++;
    if (busy !== 1'b0 || resp1_valid !== 1'b0 || result !== 16'h0000) begin
      n_fail++; $display("FAIL rst_dropped: got busy=%b resp1=%b result=%h want 0 0 0000", busy, resp1_valid, result);
    end
    drive_edge();
    set_req(0, 1'b1, OP_XOR, 16'hAAAA, 16'h5555);
    set_req(1, 1'b1, OP_OR, 16'h0001, 16'h0002);
    sample();
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_regrant: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    drive_edge();
    req0_valid = 1'b0; req1_valid = 1'b0;
    sample();
    seen = resp0_valid; cyc = 0;
    while (!seen && cyc < 5) begin
      n_checks++;
      if (resp1_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ghost_resp1: got %b want 0", resp1_valid); end
      drive_edge();
      sample();
      seen = resp0_valid;
      cyc++;
    end
    n_checks++;
    if (!seen || exp_q.size() != 1) begin
      n_fail++; $display("FAIL rst_resp0: got seen=%b sb=%0d want 1 1", seen, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (e.who != 0 || result !== e.res || statusOut !== e.st) begin
        n_fail++; $display("FAIL rst_resp0: got %h/%b want %h/%b", result, statusOut, e.res, e.st);
      end
    end
    drive_edge();
    sample();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    set_req(0, 1'b0, 4'h0, 16'h0, 16'h0);
    set_req(1, 1'b0, 4'h0, 16'h0, 16'h0);
    test_reset();
    test_single();
    test_both();
    test_fairness();
    test_stall();
    test_rst_exec();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d left want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
